cell_sweep_ctrl: RTL and testbench

- Autonomous sweep sequencer for the page-selected standard-cell test array.
- Steps the 5-bit page select and 6-bit cell input vector through a page range, waits a settle interval per vector, and captures the 8-bit cell output.
- Compacts captured outputs into a 16-bit MISR signature per page, so a whole page can be checked against a golden value.
- Sits between the host control inputs and the cell array's page/cell_in/cell_out interface.

---
 rtl/cells_pkg.sv | 23 ++
 rtl/cell_misr16.sv | 19 +
 rtl/cell_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_cell_sweep_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cells_pkg.sv
// Shared types and constants for the standard-cell sweep sequencer.
//   state_t        : sweep FSM states
//   PAGE_W/VEC_W   : page select and cell input vector widths
//   OUT_W/SIG_W    : cell output and signature widths
//   DEF_MISR_*     : default signature polynomial and per-page seed
package cells_pkg;

    localparam int PAGE_W = 5;
    localparam int VEC_W  = 6;
    localparam int OUT_W  = 8;
    localparam int SIG_W  = 16;

    localparam logic [SIG_W-1:0] DEF_MISR_POLY = 16'h1021;
    localparam logic [SIG_W-1:0] DEF_MISR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/cell_misr16.sv
// Combinational next-signature step of the page MISR.
//   misr      : current signature
//   cell_out  : captured cell array output folded into the low bits
//   misr_next : signature after one shift/feedback/fold step
module cell_misr16
    import cells_pkg::*;
#(
    parameter logic [SIG_W-1:0] POLY = DEF_MISR_POLY
) (
    input  logic [SIG_W-1:0] misr,
    input  logic [OUT_W-1:0] cell_out,
    output logic [SIG_W-1:0] misr_next
);

    assign misr_next = {misr[SIG_W-2:0], 1'b0}
                     ^ (misr[SIG_W-1] ? POLY : '0)
                     ^ {{(SIG_W-OUT_W){1'b0}}, cell_out};

endmodule

// File: rtl/cell_sweep_ctrl.sv
// Autonomous page/vector sweep sequencer for the standard-cell test array.
// Walks every 6-bit input vector of each page in [first_page, end], holds
// each vector SETTLE_CYCLES cycles, captures cell_out and compacts it into a
// per-page MISR signature.
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : host control (start sampled only in IDLE)
//   first_page/last_page : sweep range, latched on accepted start
//   page, cell_in     : registered drive to the cell array
//   cell_out          : cell array response, sampled in CAPTURE
//   busy, done        : status; done pulses one cycle at sweep end
//   sig_valid/sig_page/sig : per-page signature result
module cell_sweep_ctrl
    import cells_pkg::*;
#(
    parameter int unsigned      SETTLE_CYCLES = 2,
    parameter logic [SIG_W-1:0] MISR_POLY     = DEF_MISR_POLY,
    parameter logic [SIG_W-1:0] MISR_SEED     = DEF_MISR_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PAGE_W-1:0] first_page,
    input  logic [PAGE_W-1:0] last_page,
    output logic [PAGE_W-1:0] page,
    output logic [VEC_W-1:0]  cell_in,
    input  logic [OUT_W-1:0]  cell_out,
    output logic              busy,
    output logic              done,
    output logic              sig_valid,
    output logic [PAGE_W-1:0] sig_page,
    output logic [SIG_W-1:0]  sig
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t            state, state_nxt;
    logic [PAGE_W-1:0] cur, end_pg;
    logic [VEC_W-1:0]  vec;
    logic [SIG_W-1:0]  misr, misr_upd;
    logic [3:0]        settle_cnt;

    logic settle_last, vec_last, page_last;

    assign settle_last = (settle_cnt == SETTLE_LAST);
    assign vec_last    = &vec;
    assign page_last   = (cur == end_pg);

    // cur/vec are registers that only change on state-entry edges, so they
    // drive the array directly and stay stable across APPLY and CAPTURE.
    assign page    = cur;
    assign cell_in = vec;
    assign busy    = (state != IDLE);

    cell_misr16 #(.POLY(MISR_POLY)) u_misr (
        .misr      (misr),
        .cell_out  (cell_out),
        .misr_next (misr_upd)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY: begin
                if (abort)            state_nxt = IDLE;
                else if (settle_last) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (abort)                       state_nxt = IDLE;
                else if (vec_last && page_last)  state_nxt = DONE;
                else                             state_nxt = APPLY;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            end_pg     <= '0;
            vec        <= '0;
            misr       <= '0;
            settle_cnt <= '0;
            done       <= 1'b0;
            sig_valid  <= 1'b0;
            sig_page   <= '0;
            sig        <= '0;
        end else begin
            state     <= state_nxt;
            done      <= 1'b0;
            sig_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur        <= first_page;
                        // Inverted range collapses to a single-page sweep.
                        end_pg     <= (last_page < first_page) ? first_page : last_page;
                        vec        <= '0;
                        misr       <= MISR_SEED;
                        settle_cnt <= '0;
                    end
                end
                APPLY: begin
                    if (abort || settle_last) settle_cnt <= '0;
                    else                      settle_cnt <= settle_cnt + 4'd1;
                end
                CAPTURE: begin
                    if (!abort) begin
                        if (!vec_last) begin
                            vec  <= vec + 1'b1;
                            misr <= misr_upd;
                        end else begin
                            // Final vector of the page: publish the signature
                            // including this capture, then roll to next page.
                            sig       <= misr_upd;
                            sig_page  <= cur;
                            sig_valid <= 1'b1;
                            if (!page_last) begin
                                cur  <= cur + 1'b1;
                                vec  <= '0;
                                misr <= MISR_SEED;
                            end
                        end
                    end
                end
                DONE: begin
                    // Registered so an abort in DONE can still suppress it.
                    if (!abort) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_sweep_ctrl.sv
module tb_cell_sweep_ctrl;
    import cells_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [4:0]  first_page, last_page, page, sig_page;
    logic [5:0]  cell_in;
    logic [7:0]  cell_out;
    logic        busy, done, sig_valid;
    logic [15:0] sig;

    logic        use_model;
    logic [7:0]  co_const;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cell_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_page(first_page), .last_page(last_page),
        .page(page), .cell_in(cell_in), .cell_out(cell_out),
        .busy(busy), .done(done), .sig_valid(sig_valid),
        .sig_page(sig_page), .sig(sig)
    );

    function automatic logic [7:0] cell_fn(input logic [4:0] p, input logic [5:0] v);
        return ({p, 3'b000} + {2'b00, v}) ^ 8'hA5;
    endfunction

    assign cell_out = use_model ? cell_fn(page, cell_in) : co_const;

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [7:0] d);
        logic [15:0] n;
        n = {m[14:0], 1'b0};
        if (m[15]) n = n ^ 16'h1021;
        return n ^ {8'h00, d};
    endfunction

    function automatic logic [15:0] page_sig(input logic [4:0] p);
        logic [15:0] m;
        m = 16'hFFFF;
        for (int v = 0; v < 64; v++)
            m = misr_step(m, use_model ? cell_fn(p, 6'(v)) : co_const);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-run observation log
    int          done_cnt, done_at, sv_cnt, walk_err, max_page, min_page;
    int          exp_first, exp_np;
    logic [4:0]  sv_page[$];
    logic [15:0] sv_sig[$];

    task automatic launch(input logic [4:0] f, input logic [4:0] l);
        first_page = f;
        last_page  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Runs ncyc cycles after the start-accept edge; n counts edges since it.
    task automatic run(input int ncyc, input int pulse_at);
        done_cnt = 0; done_at = -1; sv_cnt = 0; walk_err = 0;
        max_page = 0; min_page = 31;
        sv_page.delete(); sv_sig.delete();
        for (int n = 1; n <= ncyc; n++) begin
            start = (n == pulse_at);
            tick();
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (sig_valid) begin
                sv_cnt++;
                sv_page.push_back(sig_page);
                sv_sig.push_back(sig);
            end
            if (n < exp_np * 192) begin
                if (page !== 5'(exp_first + n / 192) || cell_in !== 6'((n % 192) / 3))
                    walk_err++;
            end
            if (busy) begin
                if (int'(page) > max_page) max_page = int'(page);
                if (int'(page) < min_page) min_page = int'(page);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        first_page = '0; last_page = '0;
        use_model = 1'b0; co_const = 8'h5A;
        tick(); tick();
        chk("rst_page", page, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sig", sig, 0);
        rst = 1'b0;
        tick();

        // 1: reset mid-sweep at page 3, vector 20
        launch(5'd3, 5'd3);
        k = 0;
        while (!(page == 5'd3 && cell_in == 6'd20) && k < 200) begin tick(); k++; end
        chk("t1_reach_vec20", k < 200, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t1_page", page, 0);
        chk("t1_cell_in", cell_in, 0);
        chk("t1_busy", busy, 0);
        chk("t1_done_sv", {done, sig_valid}, 0);
        chk("t1_sig", sig, 0);
        exp_np = 0;
        run(20, 0);
        chk("t1_quiet", done_cnt + sv_cnt + int'(busy), 0);

        // 2: single page 5, constant cell_out, start pulse while busy
        launch(5'd5, 5'd5);
        exp_first = 5; exp_np = 1;
        chk("t2_busy", busy, 1);
        tick(); tick(); tick();
        chk("t2_first_capture", dut.misr, 16'hEF85);
        // restart sweep from a clean accept for the timing run
        rst = 1'b1; tick(); rst = 1'b0; tick();
        launch(5'd5, 5'd5);
        run(200, 50);
        chk("t2_walk", walk_err, 0);
        chk("t2_sv_cnt", sv_cnt, 1);
        if (sv_cnt == 1) begin
            chk("t2_sig_page", sv_page[0], 5);
            chk("t2_sig", sv_sig[0], page_sig(5'd5));
        end
        chk("t2_done_at", done_at, 193);
        chk("t2_done_cnt", done_cnt, 1);

        // 3: pages 2..4 with a page/vector dependent cell response
        use_model = 1'b1;
        launch(5'd2, 5'd4);
        exp_first = 2; exp_np = 3;
        run(590, 0);
        chk("t3_walk", walk_err, 0);
        chk("t3_sv_cnt", sv_cnt, 3);
        if (sv_cnt == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t3_sig_page", sv_page[i], 2 + i);
                chk("t3_sig", sv_sig[i], page_sig(5'(2 + i)));
            end
        end
        chk("t3_done_at", done_at, 577);

        // 4: abort during page 3 of a 2..4 sweep
        launch(5'd2, 5'd4);
        k = 0; sv_cnt = 0;
        while (!(page == 5'd3 && cell_in == 6'd10) && k < 600) begin
            tick(); k++;
            if (sig_valid) begin
                sv_cnt++;
                chk("t4_pre_sig_page", sig_page, 2);
            end
        end
        chk("t4_reach", k < 600, 1);
        chk("t4_pre_sv_cnt", sv_cnt, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        exp_np = 0;
        run(100, 0);
        chk("t4_quiet", done_cnt + sv_cnt + int'(busy), 0);
        chk("t4_sig_hold", sig, page_sig(5'd2));
        launch(5'd2, 5'd4);
        chk("t4_restart", {page, cell_in, busy}, {5'd2, 6'd0, 1'b1});
        exp_first = 2; exp_np = 3;
        run(580, 0);
        chk("t4_rerun_walk", walk_err, 0);
        chk("t4_rerun_sv", sv_cnt, 3);
        chk("t4_rerun_done", done_at, 577);

        // 5: inverted range, start on the DONE->IDLE edge is ignored
        launch(5'd7, 5'd1);
        exp_first = 7; exp_np = 1;
        run(200, 193);
        chk("t5_walk", walk_err, 0);
        chk("t5_sv_cnt", sv_cnt, 1);
        if (sv_cnt == 1) chk("t5_sig_page", sv_page[0], 7);
        chk("t5_done_at", done_at, 193);
        chk("t5_idle_after", busy, 0);

        // 6: top page only, no wrap
        launch(5'd31, 5'd31);
        exp_first = 31; exp_np = 1;
        run(205, 0);
        chk("t6_walk", walk_err, 0);
        chk("t6_page_range", {max_page[7:0], min_page[7:0]}, {8'd31, 8'd31});
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_page_hold", page, 31);
        if (sv_cnt == 1) chk("t6_sig", sv_sig[0], page_sig(5'd31));
        else chk("t6_sv_cnt", sv_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
